// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one synchronous single-port data memory between
// the processor (port 0) and the debug/loader port (port 1). Define DMEM_ARB_LOCK_EN for bus locking.
module dmem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (LOCK_MAX < 2) begin : g_lock_max_check
        $error("dmem_arbiter: LOCK_MAX must be at least 2");
    end

    logic rr_ptr_q, rr_ptr_d;
    logic rvalid0_q, rvalid1_q;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } lock_state_e;

    lock_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             blk0_q, blk1_q;
    logic             lock_own, cnt_last, lock_rel;

    // The entry transfer plus LOCK_MAX-1 locked cycles gives the owner LOCK_MAX grants.
    always_comb begin
        lock_own = (state_q == LOCK0) ? lock0 : lock1;
        cnt_inc  = cnt_q + CNT_W'(1);
        cnt_last = (cnt_inc == CNT_W'(LOCK_MAX - 1));
        lock_rel = (state_q != IDLE) && (!lock_own || cnt_last);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk0_q  <= 1'b0;
            blk1_q  <= 1'b0;
        end else begin
            if (gnt1 || !req1) blk0_q <= 1'b0;
            if (gnt0 || !req0) blk1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (gnt0 && lock0 && !blk0_q)      state_q <= LOCK0;
                    else if (gnt1 && lock1 && !blk1_q) state_q <= LOCK1;
                end
                LOCK0: begin
                    cnt_q <= cnt_inc;
                    // lock still asserted at release means a forced release: block re-entry
                    if (lock_rel) begin
                        state_q <= IDLE;
                        blk0_q  <= lock0;
                    end
                end
                LOCK1: begin
                    cnt_q <= cnt_inc;
                    if (lock_rel) begin
                        state_q <= IDLE;
                        blk1_q  <= lock1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`endif

    always_comb begin
        gnt0 = req0 & (~req1 | ~rr_ptr_q);
        gnt1 = req1 & (~req0 | rr_ptr_q);
`ifdef DMEM_ARB_LOCK_EN
        if (state_q == LOCK0) begin
            gnt0 = req0;
            gnt1 = 1'b0;
        end else if (state_q == LOCK1) begin
            gnt0 = 1'b0;
            gnt1 = req1;
        end
`endif
        if (!reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt0)      rr_ptr_d = 1'b1;
        else if (gnt1) rr_ptr_d = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        if (lock_rel) rr_ptr_d = (state_q == LOCK0);
`endif
    end

    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = (gnt0 & we0) | (gnt1 & we1);
        mem_addr  = gnt1 ? addr1 : addr0;
        mem_wdata = gnt1 ? wdata1 : wdata0;
        rvalid0   = rvalid0_q;
        rvalid1   = rvalid1_q;
        rdata0    = mem_rdata;
        rdata1    = mem_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q  <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rvalid0_q <= gnt0 & ~we0;
            rvalid1_q <= gnt1 & ~we1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural synchronous memory
// and a read-response scoreboard. Lock scenarios are built only when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int LM = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
    logic          lock0, lock1;
`endif

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] tb_mem [64];
    bit            written[64];
    logic [DW-1:0] ref_mem[64];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
`ifdef DMEM_ARB_LOCK_EN
        .lock0     (lock0),
        .lock1     (lock1),
`endif
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {8'hC3, 2'b00, a, 8'h5A, 2'b11, a};
    endfunction

    // Synchronous single-port memory, one-cycle read latency, unwritten words hold a pattern.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                tb_mem[mem_addr]  <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? tb_mem[mem_addr] : pat(mem_addr);
            end
        end
    end

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample point; retires read responses due in this cycle.
    task automatic settle();
        exp_t e;
        @(negedge clk);
        tests++;
        if (q0.size() != 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            if (rvalid0 !== 1'b1 || rdata0 !== e.data) begin
                fails++;
                $display("FAIL sb_port0 cycle %0d: got rvalid0=%b rdata0=%h, required rvalid0=1 rdata0=%h",
                         cyc, rvalid0, rdata0, e.data);
            end
        end else if (rvalid0 !== 1'b0) begin
            fails++;
            $display("FAIL sb_port0_spurious cycle %0d: got rvalid0=%b, required 0", cyc, rvalid0);
        end
        tests++;
        if (q1.size() != 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            if (rvalid1 !== 1'b1 || rdata1 !== e.data) begin
                fails++;
                $display("FAIL sb_port1 cycle %0d: got rvalid1=%b rdata1=%h, required rvalid1=1 rdata1=%h",
                         cyc, rvalid1, rdata1, e.data);
            end
        end else if (rvalid1 !== 1'b0) begin
            fails++;
            $display("FAIL sb_port1_spurious cycle %0d: got rvalid1=%b, required 0", cyc, rvalid1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 6'd1; addr1 = 6'd2;
        repeat (2) begin
            settle();
            tests++;
            if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we} !== 6'b0) begin
                fails++;
                $display("FAIL reset_outputs: got gnt0,gnt1,rvalid0,rvalid1,mem_en,mem_we=%b, required 000000",
                         {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we});
            end
            advance();
        end
        we0 = 1'b0; we1 = 1'b0;
        reset = 1'b1;
        settle();
        tests++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 6'd1) begin
            fails++;
            $display("FAIL first_grant: got gnt0=%b gnt1=%b mem_en=%b mem_addr=%0d, required 1 0 1 1",
                     gnt0, gnt1, mem_en, mem_addr);
        end
        q0.push_back('{due: cyc + 1, data: ref_mem[6'd1]});
        advance();
        settle();
        tests++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || mem_addr !== 6'd2) begin
            fails++;
            $display("FAIL second_grant: got gnt0=%b gnt1=%b mem_addr=%0d, required 0 1 2", gnt0, gnt1, mem_addr);
        end
        q1.push_back('{due: cyc + 1, data: ref_mem[6'd2]});
        advance();
        req0 = 1'b0; req1 = 1'b0;
        settle();
        advance();
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 32'hDEADBEEF;
        settle();
        tests++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 6'd5 || mem_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL wr_port0: got gnt0=%b gnt1=%b we=%b addr=%0d wdata=%h, required 1 0 1 5 deadbeef",
                     gnt0, gnt1, mem_we, mem_addr, mem_wdata);
        end
        ref_mem[6'd5] = 32'hDEADBEEF;
        advance();
        req0 = 1'b0; we0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'd5;
        settle();
        tests++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 6'd5) begin
            fails++;
            $display("FAIL rd_port1: got gnt0=%b gnt1=%b we=%b addr=%0d, required 0 1 0 5",
                     gnt0, gnt1, mem_we, mem_addr);
        end
        q1.push_back('{due: cyc + 1, data: ref_mem[6'd5]});
        advance();
        req1 = 1'b0;
        settle();
        advance();
        settle();
        advance();
    endtask

    task automatic test_alternate();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 6'd10; addr1 = 6'd20;
        for (int i = 0; i < 6; i++) begin
            logic p;
            p = i[0];
            settle();
            tests++;
            if (gnt0 !== ~p || gnt1 !== p || mem_addr !== (p ? addr1 : addr0)) begin
                fails++;
                $display("FAIL alt_grant[%0d]: got gnt0=%b gnt1=%b mem_addr=%0d, required %b %b %0d",
                         i, gnt0, gnt1, mem_addr, ~p, p, p ? addr1 : addr0);
            end
            if (p) q1.push_back('{due: cyc + 1, data: ref_mem[addr1]});
            else   q0.push_back('{due: cyc + 1, data: ref_mem[addr0]});
            advance();
            if (p) addr1 = addr1 + 6'd1;
            else   addr0 = addr0 + 6'd1;
        end
        req0 = 1'b0; req1 = 1'b0;
        settle();
        advance();
    endtask

    task automatic test_back_to_back();
        req1 = 1'b0; req0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            we0    = ~i[0];
            addr0  = 6'd30 + 6'(i / 2);
            wdata0 = 32'hCAFE0000 | 32'(i);
            settle();
            tests++;
            if (gnt0 !== 1'b1 || mem_we !== we0 || mem_addr !== addr0) begin
                fails++;
                $display("FAIL b2b[%0d]: got gnt0=%b we=%b addr=%0d, required 1 %b %0d",
                         i, gnt0, mem_we, mem_addr, we0, addr0);
            end
            if (we0) ref_mem[addr0] = wdata0;
            else     q0.push_back('{due: cyc + 1, data: ref_mem[addr0]});
            advance();
        end
        req0 = 1'b0; we0 = 1'b0;
        settle();
        advance();
        settle();
        advance();
        req0 = 1'b1; req1 = 1'b1; addr0 = 6'd33; addr1 = 6'd34;
        settle();
        tests++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            fails++;
            $display("FAIL rr_hold: got gnt0=%b gnt1=%b, required 0 1", gnt0, gnt1);
        end
        q1.push_back('{due: cyc + 1, data: ref_mem[6'd34]});
        advance();
        req1 = 1'b0;
        settle();
        tests++;
        if (gnt0 !== 1'b1 || mem_addr !== 6'd33) begin
            fails++;
            $display("FAIL rr_hold_next: got gnt0=%b mem_addr=%0d, required 1 33", gnt0, mem_addr);
        end
        q0.push_back('{due: cyc + 1, data: ref_mem[6'd33]});
        advance();
        req0 = 1'b0;
        settle();
        advance();
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd7; req1 = 1'b0;
        settle();
        tests++;
        if (gnt0 !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre_grant: got gnt0=%b, required 1", gnt0);
        end
        q0.push_back('{due: cyc + 1, data: ref_mem[6'd7]});
        advance();
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 6'd8;
        settle();
        tests++;
        if (gnt1 !== 1'b1) begin
            fails++;
            $display("FAIL mid_p1_grant: got gnt1=%b, required 1", gnt1);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (gnt1 !== 1'b0 || rvalid1 !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_async: got gnt1=%b rvalid1=%b, required 0 0", gnt1, rvalid1);
        end
        advance();
        settle();
        advance();
        reset = 1'b1; req1 = 1'b0;
        settle();
        advance();
        req0 = 1'b1; req1 = 1'b1; addr0 = 6'd9; addr1 = 6'd10;
        settle();
        tests++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            fails++;
            $display("FAIL mid_rr_reset: got gnt0=%b gnt1=%b, required 1 0", gnt0, gnt1);
        end
        q0.push_back('{due: cyc + 1, data: ref_mem[6'd9]});
        advance();
        req0 = 1'b0;
        settle();
        tests++;
        if (gnt1 !== 1'b1) begin
            fails++;
            $display("FAIL mid_after_p1: got gnt1=%b, required 1", gnt1);
        end
        q1.push_back('{due: cyc + 1, data: ref_mem[6'd10]});
        advance();
        req1 = 1'b0;
        settle();
        advance();
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock_forced();
        lock0 = 1'b0; lock1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd11; req1 = 1'b0;
        settle();
        q0.push_back('{due: cyc + 1, data: ref_mem[6'd11]});
        advance();
        addr0 = 6'd12; req1 = 1'b1; we1 = 1'b0; lock1 = 1'b1; addr1 = 6'd40;
        for (int i = 0; i < LM; i++) begin
            settle();
            tests++;
            if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
                fails++;
                $display("FAIL lock1_hold[%0d]: got gnt0=%b gnt1=%b, required 0 1", i, gnt0, gnt1);
            end
            q1.push_back('{due: cyc + 1, data: ref_mem[addr1]});
            advance();
            addr1 = addr1 + 6'd1;
        end
        settle();
        tests++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            fails++;
            $display("FAIL lock1_forced_release: got gnt0=%b gnt1=%b, required 1 0", gnt0, gnt1);
        end
        q0.push_back('{due: cyc + 1, data: ref_mem[6'd12]});
        advance();
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        settle();
        advance();
    endtask

    task automatic test_lock_release();
        req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 6'd13; req1 = 1'b0;
        settle();
        q0.push_back('{due: cyc + 1, data: ref_mem[6'd13]});
        advance();
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'd50;
        for (int i = 0; i < 2; i++) begin
            addr0 = 6'd14 + 6'(i);
            lock0 = (i == 0);
            settle();
            tests++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                fails++;
                $display("FAIL lock0_hold[%0d]: got gnt0=%b gnt1=%b, required 1 0", i, gnt0, gnt1);
            end
            q0.push_back('{due: cyc + 1, data: ref_mem[addr0]});
            advance();
        end
        addr0 = 6'd16;
        settle();
        tests++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            fails++;
            $display("FAIL lock0_release: got gnt0=%b gnt1=%b, required 0 1", gnt0, gnt1);
        end
        q1.push_back('{due: cyc + 1, data: ref_mem[6'd50]});
        advance();
        req1 = 1'b0;
        settle();
        q0.push_back('{due: cyc + 1, data: ref_mem[6'd16]});
        advance();
        req0 = 1'b0;
        settle();
        advance();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = pat(6'(i));
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
`ifdef DMEM_ARB_LOCK_EN
        lock0 = 1'b0; lock1 = 1'b0;
`endif
        #2;
        test_reset();
        test_write_read();
        test_alternate();
        test_back_to_back();
        test_reset_mid();
`ifdef DMEM_ARB_LOCK_EN
        test_lock_forced();
        test_lock_release();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, word-address width (64-word data memory).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter LOCK_MAX, default 8, maximum cycles one port may hold a lock (only used with DMEM_ARB_LOCK_EN).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-006 req0, req1  input  1 each  port request (port 0 = processor, port 1 = debug/loader).
REQ-007 we0, we1  input  1 each  1 = write, 0 = read.
REQ-008 addr0, addr1  input  ADDR_W each  word address.
REQ-009 wdata0, wdata1  input  DATA_W each  write data.
REQ-010 gnt0, gnt1  output  1 each  combinational grant; a transfer occurs in a cycle where req and gnt are both high.
REQ-011 rvalid0, rvalid1  output  1 each  registered read-data valid.
REQ-012 rdata0, rdata1  output  DATA_W each  read data, meaningful only while the matching rvalid is high.
REQ-013 mem_en, mem_we  output  1 each  memory enable / write enable.
REQ-014 mem_addr, mem_wdata  output  ADDR_W / DATA_W  memory address and write data.
REQ-015 mem_rdata  input  DATA_W  synchronous single-port memory read data, one-cycle latency.
REQ-016 lock0, lock1  input  1 each  lock request, present only with DMEM_ARB_LOCK_EN.

Function
REQ-017 At most one of gnt0/gnt1 shall be high in any cycle; a gnt is never high without its req.
REQ-018 With exactly one req high (and no lock held by the other port), that port shall be granted in the same cycle.
REQ-019 With both req high, the port selected by a 1-bit round-robin pointer rr_ptr shall be granted.
REQ-020 After any transfer by port p, rr_ptr shall become the other port on the next edge; with no transfer, rr_ptr holds.
REQ-021 mem_en shall equal (gnt0|gnt1); mem_we/mem_addr/mem_wdata shall be the granted port's we/addr/wdata; with no grant, mem_we = 0.
REQ-022 A read transfer by port p in cycle N shall raise rvalid_p for exactly cycle N+1, with rdata_p = mem_rdata; write transfers produce no rvalid.
REQ-023 Back-to-back transfers shall be accepted every cycle; sustained dual requests alternate 0,1,0,1.
REQ-024 No forwarding: a write followed next cycle by a read to the same address returns whatever the memory returns.
REQ-025 A requester that is not granted shall hold req, we, addr and wdata stable until granted.

Reset
REQ-026 While reset is low: gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, mem_en = mem_we = 0, rr_ptr = 0 (port 0 first), lock state IDLE, lock counter 0.
REQ-027 Reset asserted mid-operation shall drop any pending rvalid; no response shall appear after reset is released.
REQ-028 The first grant after reset release with both requesting shall go to port 0.

Configuration
REQ-029 Macro DMEM_ARB_LOCK_EN defined: lock0/lock1 ports exist; FSM states IDLE, LOCK0, LOCK1.
REQ-030 With the macro: a transfer by port p with lock_p = 1 in IDLE moves the FSM to LOCKp and clears the lock counter.
REQ-031 In LOCKp only port p may be granted; the other port stalls regardless of rr_ptr; the counter increments every cycle in LOCKp.
REQ-032 LOCKp shall return to IDLE when lock_p is low at a clock edge, or when the counter reaches LOCK_MAX-1 (forced release); on either release rr_ptr becomes the other port.
REQ-033 After a forced release, port p shall not re-enter LOCKp until the other port has completed a transfer or stopped requesting.
REQ-034 Without the macro: no lock ports, no FSM or counter; behaviour is pure round-robin per REQ-017..025.

Verification
REQ-035 Reset low, both req high -> gnt0 = gnt1 = 0, rvalid = 0; release reset -> first gnt0 = 1.
REQ-036 Port 0 writes 0xDEADBEEF to addr 5, next cycle port 1 reads addr 5 -> gnt1 in that cycle, rvalid1 the following cycle with rdata1 = 0xDEADBEEF.
REQ-037 Both ports read continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each rvalid pulse is one cycle after its grant.
REQ-038 Reset pulled low the cycle after a port-1 read grant -> rvalid1 never asserts.
REQ-039 (DMEM_ARB_LOCK_EN, LOCK_MAX = 8) Port 1 locks and holds lock1 with port 0 requesting -> port 1 granted 8 consecutive cycles, then gnt0 = 1.
REQ-040 (DMEM_ARB_LOCK_EN) Port 0 locks for 3 cycles, drops lock0 -> FSM IDLE, next contested grant goes to port 1.
